sync_fifo_prog: RTL and testbench
=================================

# sync_fifo_prog

Parametrised synchronous FIFO that succeeds the fixed 16x8 FIFO in the FIFO verification environment. It adds programmable almost-full and almost-empty thresholds, an occupancy count output, and read/write pass-through when full. It also offers an optional first-word-fall-through (FWFT) read mode. It keeps the existing handshake and status port set, so the existing FIFO assertion and UVM components carry over.

## Interface
- FIFO_WIDTH, 16, data word width in bits (≥1)
- FIFO_DEPTH, 8, number of entries; must be a power of 2 and ≥4
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count ≥ AF_THRESH (legal range 1..FIFO_DEPTH-1)
- AE_THRESH, 1, almostempty asserts when count ≤ AE_THRESH (legal range 1..FIFO_DEPTH-1, must be < AF_THRESH)
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out  out  FIFO_WIDTH  read data
- wr_ack  out  1  registered, previous-cycle write was accepted
- overflow  out  1  registered, previous-cycle write was rejected
- underflow  out  1  registered, previous-cycle read was rejected
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almostfull  out  1  AF_THRESH ≤ count < FIFO_DEPTH
- almostempty  out  1  0 < count ≤ AE_THRESH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH

## Operation
- Storage: FIFO_DEPTH x FIFO_WIDTH array, with wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits that wrap naturally from DEPTH-1 to 0. The array has no reset.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_en).
  - When the FIFO is full and both requests are asserted, both are accepted (pass-through).
  - The read returns the old head word. The write lands in the freed slot.
- Empty with both requests asserted: the write is accepted, the read is rejected (underflow=1 next cycle).
- Count update: count += wr_ok - rd_ok. Simultaneous accepted read and write leave count unchanged.
- Flags full, empty, almostfull and almostempty are combinational decodes of count, with no extra latency.
- wr_ack = wr_ok, overflow = wr_en && !wr_ok, underflow = rd_en && !rd_ok. Each is registered for exactly one cycle.
- Reset (rst_n=0, takes effect immediately):
  - ptrs=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
  - Flags become empty=1, full=0, almostfull=0, almostempty=0.
  - Reset during traffic discards all contents. The first operation after release behaves as on an empty FIFO.

## Timing
- Write accepted at edge N: count, flags and wr_ack reflect it after edge N. The word is readable from the cycle after edge N.
- Standard mode read: rd_ok at edge N loads data_out with mem[rd_ptr] at edge N. data_out is valid after edge N (1-cycle latency) and holds until the next accepted read.
- Rejected requests change no pointer, count or data_out. Only overflow or underflow pulses.
- Error/ack outputs deassert one cycle after the causing request is removed; they are never sticky.

## Configuration
- Macro `FIFO_FWFT_EN`.
- Defined (FWFT mode):
  - data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty.
  - A word written at edge N appears on data_out after edge N.
  - rd_en acts as a pop, advancing to the next word after the edge.
  - Flag, count and handshake behaviour is identical to standard mode.
- Undefined: standard registered read as described in Timing. This is the default.

## Test plan
- Reset then fill: with WIDTH=16 and DEPTH=8, write 0x0001..0x0008 on 8 consecutive cycles.
  - Each write gives wr_ack=1 next cycle.
  - almostfull asserts when count=7. full asserts with count=8 after the 8th write.
  - A 9th write gives overflow=1 and count stays 8.
- Drain: read 8 times.
  - data_out shows 0x0001..0x0008 in order, each one cycle after its read.
  - almostempty=1 at count=1, then empty=1.
  - A 9th read gives underflow=1 and data_out holds 0x0008.
- Pass-through when full: with the FIFO full of 0x0001..0x0008, assert wr_en+rd_en with data_in=0xABCD.
  - data_out=0x0001, wr_ack=1, overflow=0, count stays 8.
  - A later drain returns 0x0002..0x0008 then 0xABCD.
- Empty with simultaneous requests: wr_en+rd_en with data_in=0x1234.
  - Next cycle: count=1, wr_ack=1, underflow=1.
- Wrap and reset mid-operation:
  - Perform 12 writes interleaved with 12 reads so the pointers wrap; the data order is preserved.
  - Assert rst_n=0 asynchronously with count=5; all outputs return to reset values before the next edge.
- Thresholds and FWFT: with AF_THRESH=6 and AE_THRESH=2, almostfull is 1 at count 6–7 and almostempty is 1 at count 1–2.
  - With `FIFO_FWFT_EN` defined, write 0x00AA: data_out=0x00AA in the cycle after the write, with no read issued.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//   Parametrised synchronous FIFO with programmable almost-full/almost-empty
//   thresholds, an occupancy count, and pass-through of simultaneous
//   read+write when full.
//
//   Optional feature: define FIFO_FWFT_EN for first-word-fall-through reads
//   (data_out shows the head word combinationally). When it is undefined,
//   reads are registered with 1-cycle latency.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   data_in      in   write data
//   wr_en/rd_en  in   write/read requests
//   data_out     out  read data
//   wr_ack       out  previous-cycle write accepted
//   overflow     out  previous-cycle write rejected
//   underflow    out  previous-cycle read rejected
//   full/empty   out  count == FIFO_DEPTH / count == 0
//   almostfull   out  AF_THRESH <= count < FIFO_DEPTH
//   almostempty  out  0 < count <= AE_THRESH
//   count        out  occupancy 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          full,
    output logic                          empty,
    output logic                          almostfull,
    output logic                          almostempty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, overflow_q, underflow_q;
    logic          wr_ok, rd_ok;

    // Status flags are pure decodes of the occupancy count.
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= AF_C) && !full;
    assign almostempty = !empty && (count_q <= AE_C);
    assign count       = count_q;

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A full FIFO still takes a write when a read frees the head slot in
    // the same cycle (pass-through).
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ok;
            overflow_q  <= wr_en && !wr_ok;
            underflow_q <= rd_en && !rd_ok;
        end
    end

    // Storage carries no reset; contents are only visible through pointers.
    // On pass-through the write lands in the slot being read; the read side
    // still samples the old word because both use pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through combinationally; forced to zero when empty so
    // stale storage never leaks out.
    assign data_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        data_out_d = data_out_q;
        if (rd_ok) data_out_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out_q <= '0;
        else        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        wr_en, rd_en;

    logic [15:0] data_out, b_data_out;
    logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic        b_wr_ack, b_overflow, b_underflow, b_full, b_empty, b_almostfull, b_almostempty;
    logic [3:0]  count, b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .count(count)
    );

    // Second instance with custom thresholds, driven by the same stimulus.
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut_t (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(b_data_out), .wr_ack(b_wr_ack), .overflow(b_overflow), .underflow(b_underflow),
        .full(b_full), .empty(b_empty), .almostfull(b_almostfull), .almostempty(b_almostempty),
        .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Pop one word and check it; in FWFT mode the word is visible before the pop.
    task automatic read_chk(input string tag, input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        chk(tag, data_out, exp);
        step(1'b0, 1'b1, 16'h0);
`else
        step(1'b0, 1'b1, 16'h0);
        chk(tag, data_out, exp);
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almostempty, 0);
        chk("rst_af", almostfull, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_ack", wr_ack, 0);
        @(negedge clk); rst_n = 1'b1;

        // Fill 1..8
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 16'(k));
            chk("fill_ack", wr_ack, 1);
            chk("fill_count", count, k);
            chk("fill_af", almostfull, (k == 7));
            chk("fill_full", full, (k == 8));
            chk("fill_ae", almostempty, (k == 1));
            chk("thr_af", b_almostfull, (k == 6 || k == 7));
            chk("thr_ae", b_almostempty, (k == 1 || k == 2));
        end
        step(1'b1, 1'b0, 16'h0009);
        chk("ovf", overflow, 1);
        chk("ovf_ack", wr_ack, 0);
        chk("ovf_count", count, 8);
        step(1'b0, 1'b0, 16'h0);
        chk("ovf_clear", overflow, 0);

        // Drain
        for (int k = 1; k <= 8; k++) begin
            read_chk("drain_data", 16'(k));
            chk("drain_count", count, 8 - k);
            chk("drain_ae", almostempty, (k == 7));
            chk("drain_empty", empty, (k == 8));
            chk("thr_ae_d", b_almostempty, (k == 6 || k == 7));
        end
        step(1'b0, 1'b1, 16'h0);
        chk("udf", underflow, 1);
        chk("udf_count", count, 0);
`ifdef FIFO_FWFT_EN
        chk("udf_dout", data_out, 16'h0000);
`else
        chk("udf_dout", data_out, 16'h0008);
`endif
        step(1'b0, 1'b0, 16'h0);
        chk("udf_clear", underflow, 0);

        // Pass-through when full
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 16'(k));
        chk("pt_full", full, 1);
        step(1'b1, 1'b1, 16'hABCD);
`ifdef FIFO_FWFT_EN
        chk("pt_dout", data_out, 16'h0002);
`else
        chk("pt_dout", data_out, 16'h0001);
`endif
        chk("pt_ack", wr_ack, 1);
        chk("pt_ovf", overflow, 0);
        chk("pt_count", count, 8);
        for (int k = 2; k <= 8; k++) read_chk("pt_drain", 16'(k));
        read_chk("pt_last", 16'hABCD);
        chk("pt_empty", empty, 1);

        // Empty with simultaneous requests
        step(1'b1, 1'b1, 16'h1234);
        chk("ew_count", count, 1);
        chk("ew_ack", wr_ack, 1);
        chk("ew_udf", underflow, 1);
        read_chk("ew_data", 16'h1234);
        chk("ew_udf2", underflow, 0);
        chk("ew_count2", count, 0);

        // Wrap: 12 writes interleaved with 12 reads
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 16'(16'h0100 + i));
            chk("wrap_count1", count, 1);
            read_chk("wrap_data", 16'(16'h0100 + i));
        end
        chk("wrap_empty", empty, 1);

        // Asynchronous reset with count=5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0200 + i));
        chk("pre_rst_count", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_af", almostfull, 0);
        chk("arst_ae", almostempty, 0);
        chk("arst_ack", wr_ack, 0);
        chk("arst_dout", data_out, 0);
        chk("arst_b_count", b_count, 0);
        @(negedge clk); rst_n = 1'b1;

        // First write after reset; FWFT shows it without a read
        step(1'b1, 1'b0, 16'h00AA);
        chk("post_count", count, 1);
        chk("post_ack", wr_ack, 1);
`ifdef FIFO_FWFT_EN
        chk("fwft_dout", data_out, 16'h00AA);
`else
        chk("std_dout_hold", data_out, 16'h0000);
`endif
        read_chk("post_read", 16'h00AA);
        chk("post_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
